// File: rtl/wb_trace_pkg.sv
// Shared types for the writeback trace buffer: entry layout, FSM states, defaults.
// Pure declarations, no logic; no flow control of its own.
// Used by wb_trace_fifo consumers and wb_trace_buffer.
package wb_trace_pkg;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int PC_W    = 32;
  localparam int ENTRY_W = REG_W + DATA_W + PC_W;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_HOLD  = 100000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2
  } traceState_t;

  typedef struct packed {
    logic [REG_W-1:0]  regNum;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
  } traceEntry_t;

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic synchronous FIFO, registered storage with combinational head read.
// Latency: a push is visible at the head one cycle later; pop-when-empty is ignored.
// Backpressure: push-when-full is ignored unless a pop happens the same cycle.
module wb_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wrData,
  output logic [WIDTH-1:0]         rdData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    headPtr;
  logic [AW-1:0]    tailPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdData = mem[headPtr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + 1'b1;
      if (doPop)  headPtr <= headPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[tailPtr] <= wrData;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures WB-stage writebacks into a FIFO and paces them onto a held display bus.
// Latency: push to display in 2 edges from idle; advance to new entry in 2 edges.
// Backpressure: none upstream; pushes into a full FIFO are dropped (WB_TRACE_DROP_CNT_EN counts them).
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int HOLD  = DEFAULT_HOLD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [REG_W-1:0]           wb_reg,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic [PC_W-1:0]            wb_pc,
  input  logic                       auto_mode,
  input  logic                       step,
  output logic                       disp_valid,
  output logic [REG_W-1:0]           disp_reg,
  output logic [DATA_W-1:0]          disp_data,
  output logic [PC_W-1:0]            disp_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  traceState_t         state;
  traceEntry_t         wbEntry;
  traceEntry_t         headEntry;
  traceEntry_t         dispEntry;
  logic [ENTRY_W-1:0]  headRaw;
  logic                fifoFull;
  logic                fifoEmpty;
  logic                popReq;
  logic                drop;
  logic                advance;
  logic                dispValid;
  logic [HOLD_W-1:0]   holdCnt;

  assign wbEntry = '{regNum: wb_reg, data: wb_data, pc: wb_pc};
  assign headEntry = headRaw;

  assign popReq  = (state == LOAD);
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives.
  assign drop    = wb_valid && fifoFull && !popReq;
  assign advance = step || (auto_mode && (holdCnt == '0));

  wb_trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (wb_valid),
    .pop    (popReq),
    .wrData (wbEntry),
    .rdData (headRaw),
    .full   (fifoFull),
    .empty  (fifoEmpty),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dispEntry <= '0;
      dispValid <= 1'b0;
      holdCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifoEmpty) state <= LOAD;
        end
        LOAD: begin
          dispEntry <= headEntry;
          dispValid <= 1'b1;
          holdCnt   <= HOLD_W'(HOLD - 1);
          state     <= SHOW;
        end
        SHOW: begin
          if (holdCnt != '0) holdCnt <= holdCnt - 1'b1;
          // With nothing buffered the request is dropped and the last entry stays up.
          if (advance && !fifoEmpty) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef WB_TRACE_DROP_CNT_EN
  logic [7:0] dropCnt;

  always_ff @(posedge clk) begin
    if (rst) dropCnt <= 8'd0;
    else if (drop && (dropCnt != 8'hFF)) dropCnt <= dropCnt + 1'b1;
  end

  assign drop_cnt = dropCnt;
`else
  assign drop_cnt = 8'd0;
`endif

  assign disp_valid = dispValid;
  assign disp_reg   = dispEntry.regNum;
  assign disp_data  = dispEntry.data;
  assign disp_pc    = dispEntry.pc;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with DEPTH=4, HOLD=4; inputs driven and outputs
// sampled on the falling edge, so each @(negedge) follows exactly one active edge.
module tb_wb_trace_buffer;
  import wb_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        auto_mode;
  logic        step;
  logic        disp_valid;
  logic [4:0]  disp_reg;
  logic [31:0] disp_data;
  logic [31:0] disp_pc;
  logic [2:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int nAsserts = 0;
  int nFails   = 0;
  logic [7:0] expDrop;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(4), .HOLD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_reg     (wb_reg),
    .wb_data    (wb_data),
    .wb_pc      (wb_pc),
    .auto_mode  (auto_mode),
    .step       (step),
    .disp_valid (disp_valid),
    .disp_reg   (disp_reg),
    .disp_data  (disp_data),
    .disp_pc    (disp_pc),
    .count      (count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setPush(input logic [4:0] r, input logic [31:0] d, input logic [31:0] p);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    wb_pc    = p;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
`ifdef WB_TRACE_DROP_CNT_EN
    expDrop = 8'd2;
`else
    expDrop = 8'd0;
`endif
    rst = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0; wb_pc = '0;
    auto_mode = 1'b0; step = 1'b0;
    tick(1);
    doReset();

    // Reset state
    check("rst_disp_valid", 32'(disp_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_disp_data", disp_data, 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // Single push: count 1 after E, LOAD after E+1, shown after E+2
    setPush(5'd9, 32'h0000_00AB, 32'h0000_0014);
    tick(1);
    wb_valid = 1'b0;
    check("cap_count_e", 32'(count), 32'd1);
    check("cap_valid_e", 32'(disp_valid), 32'd0);
    tick(1);
    check("cap_state_e1", 32'(dut.state), 32'(LOAD));
    check("cap_valid_e1", 32'(disp_valid), 32'd0);
    tick(1);
    check("cap_valid_e2", 32'(disp_valid), 32'd1);
    check("cap_reg", 32'(disp_reg), 32'd9);
    check("cap_data", disp_data, 32'h0000_00AB);
    check("cap_pc", disp_pc, 32'h0000_0014);
    check("cap_count_e2", 32'(count), 32'd0);

    // Step mode: entry 1 auto-loads, entries 2 and 3 wait for steps
    doReset();
    setPush(5'd1, 32'h111, 32'h100); tick(1);
    setPush(5'd2, 32'h222, 32'h104); tick(1);
    setPush(5'd3, 32'h333, 32'h108); tick(1);
    wb_valid = 1'b0;
    tick(1);
    check("step_first_reg", 32'(disp_reg), 32'd1);
    check("step_first_count", 32'(count), 32'd2);
    step = 1'b1; tick(1); step = 1'b0;
    check("step1_hold_reg", 32'(disp_reg), 32'd1);
    check("step1_hold_valid", 32'(disp_valid), 32'd1);
    tick(1);
    check("step1_reg", 32'(disp_reg), 32'd2);
    check("step1_data", disp_data, 32'h222);
    check("step1_count", 32'(count), 32'd1);
    step = 1'b1; tick(1); step = 1'b0; tick(1);
    check("step2_reg", 32'(disp_reg), 32'd3);
    check("step2_pc", disp_pc, 32'h108);
    check("step2_count", 32'(count), 32'd0);
    step = 1'b1; tick(1); step = 1'b0; tick(1);
    check("step3_reg", 32'(disp_reg), 32'd3);
    check("step3_valid", 32'(disp_valid), 32'd1);
    check("step3_state", 32'(dut.state), 32'(SHOW));

    // Auto mode, HOLD=4: each entry up for 5 sample points
    doReset();
    auto_mode = 1'b1;
    setPush(5'd4, 32'hA4, 32'h200); tick(1);
    setPush(5'd5, 32'hA5, 32'h204); tick(1);
    setPush(5'd6, 32'hA6, 32'h208); tick(1);
    wb_valid = 1'b0;
    check("auto_e3_reg", 32'(disp_reg), 32'd4);
    tick(4);
    check("auto_e7_reg", 32'(disp_reg), 32'd4);
    tick(1);
    check("auto_e8_reg", 32'(disp_reg), 32'd5);
    tick(4);
    check("auto_e12_reg", 32'(disp_reg), 32'd5);
    tick(1);
    check("auto_e13_reg", 32'(disp_reg), 32'd6);
    tick(20);
    check("auto_hold_reg", 32'(disp_reg), 32'd6);
    check("auto_hold_data", disp_data, 32'hA6);
    check("auto_hold_valid", 32'(disp_valid), 32'd1);

    // Overflow: 7 pushes, display stalled
    doReset();
    auto_mode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      setPush(5'(k + 1), 32'hD0 + 32'(k), 32'h300 + 32'(4 * k));
      tick(1);
    end
    wb_valid = 1'b0;
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'(expDrop));
    check("ovf_disp_reg", 32'(disp_reg), 32'd1);

    // Full FIFO: push coinciding with the step-triggered pop is kept
    step = 1'b1; tick(1); step = 1'b0;
    setPush(5'd8, 32'hEE, 32'h400); tick(1);
    wb_valid = 1'b0;
    check("full_pp_count", 32'(count), 32'd4);
    check("full_pp_drop_cnt", 32'(drop_cnt), 32'(expDrop));
    check("full_pp_reg", 32'(disp_reg), 32'd2);
    for (int s = 0; s < 4; s++) begin
      step = 1'b1; tick(1); step = 1'b0; tick(1);
    end
    check("full_tail_reg", 32'(disp_reg), 32'd8);
    check("full_tail_data", disp_data, 32'hEE);
    check("full_tail_count", 32'(count), 32'd0);

    // Reset while showing with count=3; push in the reset cycle is discarded
    setPush(5'd10, 32'hF0, 32'h500); tick(1);
    setPush(5'd11, 32'hF1, 32'h504); tick(1);
    setPush(5'd12, 32'hF2, 32'h508); tick(1);
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_state", 32'(dut.state), 32'(SHOW));
    rst = 1'b1;
    setPush(5'd13, 32'hF3, 32'h50C);
    tick(1);
    rst = 1'b0;
    wb_valid = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(disp_valid), 32'd0);
    check("mid_rst_reg", 32'(disp_reg), 32'd0);
    check("mid_rst_data", disp_data, 32'd0);
    check("mid_rst_pc", disp_pc, 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("mid_rst_state", 32'(dut.state), 32'(IDLE));
    tick(3);
    check("post_rst_count", 32'(count), 32'd0);
    check("post_rst_valid", 32'(disp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Capture-and-replay buffer for register-file writebacks from the pipelined datapath's WB stage. Every qualified writeback (register number, write data, PC) is pushed into a small FIFO at full pipeline rate. A pacing FSM pops one entry at a time onto a held display bus at human speed, driven by a step pulse or an auto-advance timer. The display bus feeds the seven-segment driver, so SAD program execution can be inspected write by write instead of only seeing the live, fast-changing WriteData.

## Interface
- `DEPTH`, 16 — FIFO entries; power of two, ≥2.
- `HOLD`, 100000000 — cycles each entry is shown in auto mode; ≥1.
- `clk`  in  1  — datapath clock (same domain as the WB stage).
- `rst`  in  1  — reset. One clock; reset is synchronous and active-high.
- `wb_valid`  in  1  — writeback qualifier (regWrite of WB stage); one push per high cycle.
- `wb_reg`  in  5  — destination register.
- `wb_data`  in  32  — value written.
- `wb_pc`  in  32  — PC associated with the writeback.
- `auto_mode`  in  1  — 1 = timer advance, 0 = step-only advance.
- `step`  in  1  — single-cycle advance pulse (already debounced/edge-detected upstream).
- `disp_valid`  out  1  — display bus holds a captured entry.
- `disp_reg`  out  5  — shown register.
- `disp_data`  out  32  — shown data.
- `disp_pc`  out  32  — shown PC.
- `count`  out  $clog2(DEPTH)+1  — FIFO occupancy.
- `overflow`  out  1  — sticky: a push was dropped.
- `drop_cnt`  out  8  — dropped-push counter (see Configuration).

## Operation
- Entry = {reg, data, pc}, 69 bits.
- Push: `wb_valid`=1 and not full → entry written at tail, tail++. `wb_valid`=1 and full and no pop that cycle → entry dropped, `overflow` set.
- Full with simultaneous pop and push: both happen, count unchanged, no drop.
- Pointers wrap modulo DEPTH; `count` ranges 0..DEPTH.
- FSM states: IDLE, LOAD, SHOW.
  - IDLE: `disp_valid`=0. count≠0 → LOAD.
  - LOAD: head entry copied into display registers, pop, → SHOW; hold counter loaded with HOLD-1.
  - SHOW: `disp_valid`=1, hold counter decrements to 0 and saturates. Advance = `step` or (`auto_mode` and counter=0). Advance with count≠0 → LOAD. Advance with count=0 → stay in SHOW and keep showing the last entry; the request is not remembered.
- `step` while in IDLE or LOAD is ignored.
- `auto_mode` may change at any time. It takes effect on the next SHOW cycle.
- `overflow` clears only on `rst`.

## Timing
- Reset values: state IDLE, pointers 0, `count`=0, `disp_valid`=0, `disp_reg`/`disp_data`/`disp_pc`=0, `overflow`=0, `drop_cnt`=0, hold counter 0.
- `rst` mid-operation discards all FIFO contents and the displayed entry. `rst` has priority over a push in the same cycle.
- Capture latency: with FIFO empty and FSM in IDLE, a push sampled at edge E gives `count`=1 after E. The FSM is in LOAD after E+1. `disp_valid`=1 with the new entry after E+2, and `count` returns to 0.
- Advance latency: advance sampled at edge A with count≠0 → LOAD after A. The new entry is shown after A+1. `disp_valid` stays 1 throughout, because the display registers hold until overwritten.
- Auto mode: each entry is shown exactly HOLD cycles plus 1 LOAD cycle, provided the FIFO stays non-empty.
- `count`, `overflow` and `drop_cnt` are all registered.

## Configuration
- `WB_TRACE_DROP_CNT_EN` defined:
  - `drop_cnt` increments on every dropped push.
  - It saturates at 255 and clears on `rst`.
- `WB_TRACE_DROP_CNT_EN` undefined:
  - `drop_cnt` is tied to 8'd0 and no counter logic is built.
  - `overflow` behaves the same in both builds.

## Structure
- Package `wb_trace_pkg`:
  - FSM state enum (IDLE/LOAD/SHOW).
  - Entry field widths (REG_W=5, DATA_W=32, PC_W=32, ENTRY_W=69).
  - Default DEPTH and HOLD.
- Sub-module `wb_trace_fifo`:
  - Synchronous FIFO with push, pop, full, empty and count.
  - Head entry read combinationally (registered storage, mux read).
  - Drop detection stays in the parent.

## Test plan
- Reset then single push (wb_reg=5'd9, wb_data=32'h0000_00AB, wb_pc=32'h0000_0014) → `disp_valid`=1 with those values exactly 2 edges after the push; `count` back to 0.
- auto_mode=0, push 3 entries, pulse `step` twice → entries 2 and 3 appear in order, each 2 edges after the step. A third step leaves entry 3 shown.
- HOLD=4, auto_mode=1, push 3 entries back-to-back → each shown 5 cycles; entry 3 then held indefinitely.
- DEPTH=4, display stalled (auto_mode=0), 7 consecutive pushes → `count` stays at 4, `overflow`=1, `drop_cnt`=2 with macro and 0 without. (The first push is popped to the display, 4 are buffered, 2 are dropped.)
- Full FIFO, `step` and `wb_valid` in the same cycle → no drop, `count` stays 4, new entry at tail.
- Assert `rst` while SHOW with `count`=3 → after the edge, all outputs are 0 and state is IDLE. A push in the reset cycle is not captured.
